// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: datapath widths, RV32I opcode values,
// the fetch buffer entry payload and the credit counter width.
package instr_fetch_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ILEN     = 32;
    localparam int unsigned OPCODE_W = 7;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Holds 0..2 for both the in-flight request count and the drop count.
    localparam int unsigned CNT_W = 2;

    // RV32I major opcodes, as seen by the decoder
    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;

    // One buffered instruction together with the PC it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle.
//   imem_req_*  : word read requests to instruction memory (valid/ready)
//   imem_rsp_*  : in-order read data returning from instruction memory
//   redirect_*  : PC change from branch/jump resolution
//   dec_*       : instruction stream to decode (valid/ready)
// master = fetch stage, slave = memory / resolver / decoder side.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic                imem_req_valid;
    logic [XLEN-1:0]     imem_req_addr;
    logic                imem_req_ready;
    logic                imem_rsp_valid;
    logic [ILEN-1:0]     imem_rsp_data;
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic                dec_valid;
    logic                dec_ready;
    logic [XLEN-1:0]     dec_pc;
    logic [ILEN-1:0]     dec_instr;
    logic [OPCODE_W-1:0] dec_opcode;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output dec_valid, dec_pc, dec_instr, dec_opcode,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  dec_valid, dec_pc, dec_instr, dec_opcode,
        output dec_ready
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Two-entry instruction buffer of {pc, instr} with synchronous flush.
//   i_push/i_data : write one entry (caller guarantees a free slot)
//   i_pop         : drop the head entry (ignored when empty)
//   i_flush       : discard everything; overrides push and pop
//   o_head        : current head entry (straight from storage)
//   o_count/o_empty/o_full : occupancy
module instr_fetch_fifo
    import instr_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  fetch_entry_t     i_data,
    input  logic             i_pop,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    fetch_entry_t     r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(2));

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, issues word reads to instruction memory
// under a 2-credit limit, tags responses with their request PC, buffers
// them and presents {pc, instr, opcode} to decode. Redirects flush the
// buffer and discard every response still in flight.
//   clk, rst_n : clock, asynchronous active-low reset
//   io_bus     : instr_fetch_if.master (imem request/response, redirect, decode)
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_fetch_if.master  io_bus
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [XLEN-1:0]  r_tag [2];

    logic [XLEN-1:0]  w_tag_nxt [2];
    logic [CNT_W-1:0] w_drop_nxt;
    logic [CNT_W-1:0] w_fifo_count;
    logic [SUM_W-1:0] w_credit_sum;
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_req_valid;
    logic             w_accept;
    logic             w_rsp;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_idx;
    fetch_entry_t     w_push_data;
    fetch_entry_t     w_head;

    // Credit: requests in flight plus buffered entries never exceed the buffer size
    assign w_credit_sum  = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_req_valid   = rst_n && !io_bus.redirect_valid
                           && (w_credit_sum < SUM_W'(FIFO_DEPTH));
    assign w_accept      = w_req_valid && io_bus.imem_req_ready;
    assign w_redirect_pc = io_bus.redirect_pc & ~32'h3;

    // A response in a redirect cycle is stale even when no drops are pending
    assign w_rsp  = io_bus.imem_rsp_valid;
    assign w_push = w_rsp && !io_bus.redirect_valid && (r_drop_cnt == '0);
    assign w_pop  = !w_empty && io_bus.dec_ready;

    assign w_push_data.pc    = r_tag[0];
    assign w_push_data.instr = io_bus.imem_rsp_data;

    assign io_bus.imem_req_valid = w_req_valid;
    assign io_bus.imem_req_addr  = r_pc;
    assign io_bus.dec_valid      = !w_empty;
    assign io_bus.dec_pc         = w_head.pc;
    assign io_bus.dec_instr      = w_head.instr;
    assign io_bus.dec_opcode     = w_head.instr[OPCODE_W-1:0];

    // Tag queue slot for a new request: slot 0 once the oldest leaves, else after it
    assign w_wr_idx = !w_rsp && (r_outstanding != '0);

    // Tag queue update: pop oldest on response, append PC on acceptance
    always_comb begin
        w_tag_nxt = r_tag;
        if (w_rsp) begin
            w_tag_nxt[0] = r_tag[1];
        end
        if (w_accept) begin
            w_tag_nxt[w_wr_idx] = r_pc;
        end
    end

    // Drop count: redirect reloads it with what remains in flight after this cycle
    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (io_bus.redirect_valid) begin
            w_drop_nxt = r_outstanding - CNT_W'(w_rsp);
        end else if (w_rsp && (r_drop_cnt != '0)) begin
            w_drop_nxt = r_drop_cnt - CNT_W'(1);
        end
    end

    // PC, credit counter, drop counter and tag queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_tag[0]      <= '0;
            r_tag[1]      <= '0;
        end else begin
            if (io_bus.redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp);
            r_drop_cnt    <= w_drop_nxt;
            r_tag         <= w_tag_nxt;
        end
    end

    // The credit rule leaves a free slot for every accepted response
    always_ff @(posedge clk) begin
        if (rst_n && w_push && !w_pop) begin
            assert (!w_full);
        end
    end

    instr_fetch_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (io_bus.redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC   (TB_RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned last_due = 0;
    int unsigned lat = 1;
    logic [31:0] m_pc = TB_RESET_PC;
    logic [31:0] m_buf [$];
    req_t        m_infl [$];

    // Memory contents: a fixed scramble of the word address
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    // Entered and left just after a falling edge.
    task automatic step(input bit drdy, input bit qrdy, input bit redir, input logic [31:0] rpc);
        bit          rsp;
        bit          exp_rv;
        bit          acc;
        req_t        r;
        int unsigned due;
        logic [31:0] hd;
        rsp = (m_infl.size() > 0) && (m_infl[0].due <= cyc);
        bus.dec_ready      = drdy;
        bus.imem_req_ready = qrdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? instr_of(m_infl[0].addr) : $urandom;
        #1;
        exp_rv = !redir && ((m_infl.size() + m_buf.size()) < 2);
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("dec_valid", 32'(bus.dec_valid), 32'(m_buf.size() != 0));
        if (m_buf.size() != 0) begin
            hd = m_buf[0];
            chk("dec_pc", bus.dec_pc, hd);
            chk("dec_instr", bus.dec_instr, instr_of(hd));
            chk("dec_opcode", 32'(bus.dec_opcode), 32'(instr_of(hd) & 32'h7F));
        end
        acc = exp_rv && qrdy;
        r = '{addr: 32'h0, due: 0, stale: 1'b0};
        if (rsp) r = m_infl.pop_front();
        if (redir) begin
            m_buf.delete();
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_pc = rpc & ~32'h3;
        end else begin
            if (m_buf.size() != 0 && drdy) void'(m_buf.pop_front());
            if (rsp && !r.stale) m_buf.push_back(r.addr);
            if (acc) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                m_infl.push_back('{addr: m_pc, due: due, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset between edges, check outputs fall at once, then release
    task automatic do_reset(input int unsigned hold);
        rst_n = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'h0);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_dec_pc", bus.dec_pc, 32'h0);
        chk("rst_dec_instr", bus.dec_instr, 32'h0);
        chk("rst_dec_opcode", 32'(bus.dec_opcode), 32'h0);
        m_buf.delete();
        m_infl.delete();
        m_pc = TB_RESET_PC;
        last_due = 0;
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          found;
        logic [31:0] a0;
        logic [31:0] rpc;
        bus.dec_ready      = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        @(negedge clk);

        // Reset values and first request
        do_reset(2);
        chk("first_addr", bus.imem_req_addr, TB_RESET_PC);

        // Straight-line fetch, 1-cycle memory
        lat = 1;
        repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Decode stall then release
        repeat (10) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("stall_full", 32'(m_buf.size()), 32'd2);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect to 0x100 with two requests in flight, 3-cycle memory
        lat = 3;
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_infl.size() == 2) begin
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        chk("infl2_reached", 32'(found), 32'h1);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.dec_valid) begin
                chk("redir_first_pc", bus.dec_pc, 32'h0000_0100);
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        chk("redir_wait", 32'(found), 32'h1);

        // Redirect coinciding with a response, unaligned target
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_infl.size() > 0 && m_infl[0].due <= cyc) begin
                step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        chk("rsp_redir_hit", 32'(found), 32'h1);
        chk("unaligned_addr", bus.imem_req_addr, 32'h0000_0200);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Memory backpressure holds the request
        a0 = bus.imem_req_addr;
        repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("bp_addr_held", bus.imem_req_addr, a0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Randomized traffic, including redirects near the top of the address space
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) lat = $urandom_range(1, 4);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0, rpc);
        end

        // Async reset mid-stream with the buffer full
        lat = 2;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_buf.size() == 2) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 1'b1, 1'b0, 32'h0);
        end
        chk("fifo_full_reached", 32'(found), 32'h1);
        #2;
        do_reset(2);
        chk("restart_addr", bus.imem_req_addr, TB_RESET_PC);
        repeat (40) step($urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
